// File: rtl/ws2812_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_frame_ctrl
// Description : CPU-bus frame controller for a WS2812 pixel strip. Pixels are
//               written through a small register window into a local buffer.
//               Whole frames are then streamed one 24-bit {G,R,B} word at a
//               time to a downstream bit encoder over valid/ready. The strip
//               latch gap is inserted after each frame, and a one-cycle
//               interrupt pulse marks the end of every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_frame_ctrl #(
  parameter int NUM_LEDS = 8,
  parameter int IDX_W    = 3,
  parameter int CLK_FRE  = 25_175_000,
  parameter int RESET_US = 80
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cs_i,
  input  logic        R_W_n,
  input  logic [2:0]  reg_addr_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        px_valid_o,
  output logic [23:0] px_data_o,
  input  logic        px_ready_i,
  input  logic        enc_busy_i,
  output logic        frame_irq_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // Latch gap length in clocks (integer MHz times microseconds).
  localparam int c_latch_cyc = (CLK_FRE / 1_000_000) * RESET_US;
  localparam int c_lat_w     = $clog2(c_latch_cyc + 1);
  localparam logic [c_lat_w-1:0] c_lat_last = c_lat_w'(c_latch_cyc - 1);

  // Pixel counts run up to 256, so frame length and pixel counter use 9 bits.
  localparam int c_cnt_w = 9;
  localparam logic [c_cnt_w-1:0] c_num_leds = c_cnt_w'(NUM_LEDS);
  localparam logic [c_cnt_w-1:0] c_idx_mask = c_cnt_w'((1 << IDX_W) - 1);
  localparam logic [IDX_W-1:0]   c_idx_last = IDX_W'(NUM_LEDS - 1);
  localparam logic [7:0]         c_count_rst = 8'(NUM_LEDS);

  // Register map
  localparam logic [2:0] c_reg_ctrl  = 3'd0;
  localparam logic [2:0] c_reg_index = 3'd1;
  localparam logic [2:0] c_reg_r     = 3'd2;
  localparam logic [2:0] c_reg_g     = 3'd3;
  localparam logic [2:0] c_reg_b     = 3'd4;
  localparam logic [2:0] c_reg_count = 3'd5;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic                 r_auto;
  logic                 r_pending;
  logic [IDX_W-1:0]     r_index;
  logic [7:0]           r_stg_r;
  logic [7:0]           r_stg_g;
  logic [7:0]           r_stg_b;
  logic [7:0]           r_count;
  logic [c_cnt_w-1:0]   r_len;
  logic [c_cnt_w-1:0]   r_pix;
  logic [c_lat_w-1:0]   r_lat;
  logic                 r_px_valid;
  logic [23:0]          r_px_data;
  logic                 r_irq;
  logic [7:0]           r_rdata;
  logic [23:0]          r_buf [NUM_LEDS];

  // --------------------------------------------------------------------------
  // Bus decode and helper values
  // --------------------------------------------------------------------------
  logic                 w_wr;
  logic                 w_start;
  logic                 w_commit;
  logic                 w_busy;
  logic [c_cnt_w-1:0]   w_idx_ext;
  logic [IDX_W-1:0]     w_idx_new;
  logic [IDX_W-1:0]     w_index_inc;
  logic [c_cnt_w-1:0]   w_count_ext;
  logic [c_cnt_w-1:0]   w_cnt_eff;
  logic [c_cnt_w-1:0]   w_pix_inc;
  logic [7:0]           w_index_rd;

  assign w_wr     = cs_i & ~R_W_n;
  assign w_start  = w_wr & (reg_addr_i == c_reg_ctrl) & data_i[0];
  assign w_commit = w_wr & (reg_addr_i == c_reg_b);
  assign w_busy   = (r_state != ST_IDLE);

  // Pointer writes are masked to the index width; out-of-range values wrap to 0.
  assign w_idx_ext = {1'b0, data_i} & c_idx_mask;
  assign w_idx_new = (w_idx_ext >= c_num_leds) ? '0 : w_idx_ext[IDX_W-1:0];

  // Auto-increment after each committed pixel, wrapping at the buffer end.
  assign w_index_inc = (r_index == c_idx_last) ? '0 : r_index + IDX_W'(1);

  // A COUNT of zero or beyond the buffer means "whole buffer".
  assign w_count_ext = {1'b0, r_count};
  assign w_cnt_eff   = ((r_count == 8'd0) || (w_count_ext > c_num_leds)) ?
                       c_num_leds : w_count_ext;

  assign w_pix_inc  = r_pix + c_cnt_w'(1);
  assign w_index_rd = 8'(r_index);

  // --------------------------------------------------------------------------
  // Register file: control, pixel pointer, colour staging and frame length
  // --------------------------------------------------------------------------
  // Host-visible configuration registers, updated on bus writes
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_auto  <= 1'b0;
      r_index <= '0;
      r_stg_r <= '0;
      r_stg_g <= '0;
      r_stg_b <= '0;
      r_count <= c_count_rst;
    end else if (w_wr) begin
      case (reg_addr_i)
        c_reg_ctrl:  r_auto  <= data_i[1];
        c_reg_index: r_index <= w_idx_new;
        c_reg_r:     r_stg_r <= data_i;
        c_reg_g:     r_stg_g <= data_i;
        c_reg_b: begin
          r_stg_b <= data_i;
          r_index <= w_index_inc;
        end
        c_reg_count: r_count <= data_i;
        default: ;
      endcase
    end
  end

  // Pixel buffer write port; left unreset so it can map onto RAM
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      r_buf[r_index] <= {r_stg_g, r_stg_r, data_i};
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencer. A buffer commit and a FETCH of the same entry in one
  // cycle return the old contents, because the read samples before the write
  // lands. COUNT is captured once per frame so host writes cannot disturb a
  // frame already in flight.
  // --------------------------------------------------------------------------
  // Frame sequencing, latch gap timing and registered stream outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_pending  <= 1'b0;
      r_len      <= '0;
      r_pix      <= '0;
      r_lat      <= '0;
      r_px_valid <= 1'b0;
      r_px_data  <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= 1'b0;

      // A START that arrives mid-frame is remembered for after the latch gap.
      if (w_start && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start || r_auto || r_pending) begin
            r_state   <= ST_FETCH;
            r_pix     <= '0;
            r_len     <= w_cnt_eff;
            r_pending <= 1'b0;
          end
        end

        ST_FETCH: begin
          r_px_data  <= r_buf[r_pix[IDX_W-1:0]];
          r_px_valid <= 1'b1;
          r_state    <= ST_SEND;
        end

        ST_SEND: begin
          if (px_ready_i) begin
            r_px_valid <= 1'b0;
            r_pix      <= w_pix_inc;
            r_state    <= (w_pix_inc == r_len) ? ST_DRAIN : ST_FETCH;
          end
        end

        ST_DRAIN: begin
          // Wait for the encoder to finish shifting the last word out.
          if (!enc_busy_i) begin
            r_lat   <= '0;
            r_state <= ST_LATCH;
          end
        end

        ST_LATCH: begin
          if (r_lat == c_lat_last) begin
            r_irq   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_lat <= r_lat + c_lat_w'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read port
  // --------------------------------------------------------------------------
  // Registered view of the addressed register, refreshed every clock
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rdata <= '0;
    end else begin
      case (reg_addr_i)
        c_reg_ctrl:  r_rdata <= {5'b0, r_pending, r_auto, w_busy};
        c_reg_index: r_rdata <= w_index_rd;
        c_reg_r:     r_rdata <= r_stg_r;
        c_reg_g:     r_rdata <= r_stg_g;
        c_reg_b:     r_rdata <= r_stg_b;
        c_reg_count: r_rdata <= r_count;
        default:     r_rdata <= '0;
      endcase
    end
  end

  assign data_o      = r_rdata;
  assign px_valid_o  = r_px_valid;
  assign px_data_o   = r_px_data;
  assign frame_irq_o = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812_frame_ctrl
// Description : Self-checking bench for ws2812_frame_ctrl. A behavioural model
//               of the register window and pixel buffer predicts the words of
//               each frame, the latch gap length and register readback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_frame_ctrl;

  localparam int NUM   = 8;
  localparam int IDXM  = 8;      // 2**IDX_W
  localparam int LATCH = 2000;   // 25 MHz-integer * 80 us

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cs_i;
  logic        R_W_n;
  logic [2:0]  reg_addr_i;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        px_valid_o;
  logic [23:0] px_data_o;
  logic        px_ready_i;
  logic        enc_busy_i;
  logic        frame_irq_o;

  ws2812_frame_ctrl #(
    .NUM_LEDS(8), .IDX_W(3), .CLK_FRE(25_175_000), .RESET_US(80)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cs_i(cs_i), .R_W_n(R_W_n),
    .reg_addr_i(reg_addr_i), .data_i(data_i), .data_o(data_o),
    .px_valid_o(px_valid_o), .px_data_o(px_data_o), .px_ready_i(px_ready_i),
    .enc_busy_i(enc_busy_i), .frame_irq_o(frame_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [23:0] m_buf [NUM];
  int          m_idx;
  logic [7:0]  m_r, m_g, m_b, m_count;
  bit          m_auto;

  function automatic int m_len();
    if (m_count == 8'd0 || int'(m_count) > NUM) return NUM;
    return int'(m_count);
  endfunction

  task automatic m_reset();
    m_idx = 0; m_r = 0; m_g = 0; m_b = 0; m_count = 8'(NUM); m_auto = 0;
  endtask

  // ---------------- observation ----------------
  int          cyc = 0;
  logic [23:0] got_q [$];
  int          irq_cnt = 0;
  int          irq_cyc = 0;
  int          irq_long = 0;
  logic        prev_irq = 1'b0;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (px_valid_o && px_ready_i) got_q.push_back(px_data_o);
      if (frame_irq_o) begin
        irq_cnt++;
        irq_cyc = cyc;
        if (prev_irq) irq_long++;
      end
    end
    prev_irq = frame_irq_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1);
  end

  // ---------------- bus helpers ----------------
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    cs_i = 1'b1; R_W_n = 1'b0; reg_addr_i = a; data_i = d;
    tick();
    cs_i = 1'b0; R_W_n = 1'b1; reg_addr_i = 3'd0;
    case (a)
      3'd0: m_auto = d[1];
      3'd1: begin m_idx = int'(d) % IDXM; if (m_idx >= NUM) m_idx = 0; end
      3'd2: m_r = d;
      3'd3: m_g = d;
      3'd4: begin m_b = d; m_buf[m_idx] = {m_g, m_r, d}; m_idx = (m_idx + 1) % NUM; end
      3'd5: m_count = d;
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    reg_addr_i = a;
    tick();
    d = data_o;
    reg_addr_i = 3'd0;
  endtask

  // Completes the frame in flight: expects m_len() words from the model buffer,
  // then releases the encoder and measures the latch gap to the interrupt.
  task automatic run_frame(input bit rnd_ready);
    logic [23:0] exp_q [$];
    int n, base, t0, budget;
    n = m_len();
    for (int i = 0; i < n; i++) exp_q.push_back(m_buf[i]);
    base = irq_cnt;
    budget = 0;
    while (got_q.size() < n && budget < 2000) begin
      px_ready_i = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      tick();
      budget++;
    end
    px_ready_i = 1'b1;
    repeat ($urandom_range(0, 4)) tick();
    enc_busy_i = 1'b0;
    t0 = cyc;
    reg_addr_i = 3'd0;
    budget = 0;
    while (irq_cnt == base && budget < 3000) begin
      tick();
      budget++;
      if (budget == LATCH / 2) begin
        n_checks++;
        if (data_o[0] !== 1'b1) $display("FAIL latch_busy: got %0b want 1", data_o[0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (irq_cnt !== base + 1) $display("FAIL frame_irq_count: got %0d want %0d", irq_cnt - base, 1);
    else n_pass++;
    // One DRAIN cycle observes the encoder go idle, then LATCH cycles of gap.
    n_checks++;
    if (irq_cyc - t0 !== LATCH + 1) $display("FAIL latch_gap: got %0d want %0d", irq_cyc - t0, LATCH + 1);
    else n_pass++;
    n_checks++;
    if (got_q.size() !== n) $display("FAIL word_count: got %0d want %0d", got_q.size(), n);
    else n_pass++;
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL pixel_word[%0d]: got %06h want %06h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    enc_busy_i = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] rd;
    logic [7:0] exp_r [8];
    exp_r = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'(NUM), 8'h00, 8'h00};
    rst_n_i = 1'b0; cs_i = 1'b0; R_W_n = 1'b1; reg_addr_i = 3'd0; data_i = 8'h00;
    px_ready_i = 1'b0; enc_busy_i = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if ({data_o, px_valid_o, px_data_o, frame_irq_o} !== 34'h0)
      $display("FAIL reset_outputs: got %0h/%0b/%06h/%0b want 0", data_o, px_valid_o, px_data_o, frame_irq_o);
    else n_pass++;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      n_checks++;
      if (rd !== exp_r[a]) $display("FAIL reset_reg[%0d]: got %02h want %02h", a, rd, exp_r[a]);
      else n_pass++;
    end
  endtask

  task automatic test_single_pixel();
    logic [7:0] rd;
    bus_write(3'd1, 8'h00);
    bus_write(3'd2, 8'h12);
    bus_write(3'd3, 8'h34);
    bus_write(3'd4, 8'h56);
    bus_write(3'd5, 8'h01);
    got_q.delete();
    enc_busy_i = 1'b1; px_ready_i = 1'b1;
    bus_write(3'd0, 8'h01);
    bus_read(3'd0, rd);
    n_checks++;
    if (rd[0] !== 1'b1) $display("FAIL single_busy: got %0b want 1", rd[0]);
    else n_pass++;
    run_frame(1'b0);
    n_checks++;
    if (got_q.size() < 1 || got_q[0] !== 24'h341256)
      $display("FAIL single_word: got %06h want 341256", (got_q.size() > 0) ? got_q[0] : 24'h0);
    else n_pass++;
    tick();
    bus_read(3'd0, rd);
    n_checks++;
    if (rd !== 8'h00) $display("FAIL single_idle_ctrl: got %02h want 00", rd);
    else n_pass++;
  endtask

  task automatic test_fill_wrap();
    logic [7:0] rd;
    bus_write(3'd1, 8'h07);
    for (int p = 0; p < NUM; p++) begin
      bus_write(3'd2, 8'($urandom));
      bus_write(3'd3, 8'($urandom));
      bus_write(3'd4, 8'($urandom));
      if (p == 0) begin
        bus_read(3'd1, rd);
        n_checks++;
        if (rd !== 8'h00) $display("FAIL index_wrap: got %02h want 00", rd);
        else n_pass++;
      end
    end
    bus_write(3'd5, 8'h00);   // zero means the whole buffer
    got_q.delete();
    enc_busy_i = 1'b1;
    bus_write(3'd0, 8'h01);
    run_frame(1'b1);
    bus_read(3'd1, rd);
    n_checks++;
    if (rd !== 8'(m_idx) || rd !== 8'h07) $display("FAIL index_end: got %02h want 07", rd);
    else n_pass++;
    bus_read(3'd2, rd);
    n_checks++;
    if (rd !== m_r) $display("FAIL stage_r_read: got %02h want %02h", rd, m_r);
    else n_pass++;
  endtask

  task automatic test_ready_stall();
    logic [23:0] d0;
    int b;
    bus_write(3'd5, 8'd12);   // above the buffer depth -> whole buffer
    px_ready_i = 1'b0;
    got_q.delete();
    enc_busy_i = 1'b1;
    bus_write(3'd0, 8'h01);
    b = 0;
    while (!px_valid_o && b < 20) begin tick(); b++; end
    d0 = px_data_o;
    n_checks++;
    if (d0 !== m_buf[0] || px_valid_o !== 1'b1) $display("FAIL stall_first: got %06h want %06h", d0, m_buf[0]);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (px_valid_o !== 1'b1 || px_data_o !== d0)
        $display("FAIL stall_hold[%0d]: got %0b/%06h want 1/%06h", i, px_valid_o, px_data_o, d0);
      else n_pass++;
    end
    run_frame(1'b0);
  endtask

  task automatic test_pending();
    logic [7:0] rd;
    int b, base, first_irq;
    bus_write(3'd5, 8'd2);
    got_q.delete();
    enc_busy_i = 1'b1; px_ready_i = 1'b1;
    bus_write(3'd0, 8'h01);
    b = 0;
    while (got_q.size() < 2 && b < 100) begin tick(); b++; end
    base = irq_cnt;
    enc_busy_i = 1'b0;
    repeat (100) tick();
    bus_write(3'd0, 8'h01);
    bus_read(3'd0, rd);
    n_checks++;
    if (rd !== 8'h05) $display("FAIL pending_ctrl: got %02h want 05", rd);
    else n_pass++;
    b = 0;
    while (irq_cnt == base && b < 3000) begin tick(); b++; end
    got_q.delete();
    enc_busy_i = 1'b1;
    first_irq = irq_cyc;
    b = 0;
    while (!px_valid_o && b < 10) begin tick(); b++; end
    // FETCH follows the irq cycle, so valid is up two cycles after it.
    n_checks++;
    if (cyc - first_irq !== 2) $display("FAIL pending_restart: got %0d want 2", cyc - first_irq);
    else n_pass++;
    run_frame(1'b1);
    bus_read(3'd0, rd);
    n_checks++;
    if (rd !== 8'h00) $display("FAIL pending_clear: got %02h want 00", rd);
    else n_pass++;
  endtask

  task automatic test_auto();
    logic [7:0] rd;
    int b, base;
    bus_write(3'd1, 8'h00);
    for (int p = 0; p < 3; p++) begin
      bus_write(3'd2, 8'($urandom));
      bus_write(3'd3, 8'($urandom));
      bus_write(3'd4, 8'($urandom));
    end
    bus_write(3'd5, 8'd3);
    got_q.delete();
    enc_busy_i = 1'b1;
    bus_write(3'd0, 8'h02);
    for (int f = 0; f < 2; f++) begin
      run_frame(1'b1);
      got_q.delete();
    end
    b = 0;
    while (got_q.size() < 1 && b < 100) begin tick(); b++; end
    bus_write(3'd0, 8'h00);
    run_frame(1'b1);
    base = irq_cnt;
    got_q.delete();
    repeat (2500) tick();
    n_checks++;
    if (irq_cnt !== base || got_q.size() !== 0)
      $display("FAIL auto_stop: got %0d irq/%0d words want 0/0", irq_cnt - base, got_q.size());
    else n_pass++;
    bus_read(3'd0, rd);
    n_checks++;
    if (rd !== 8'h00) $display("FAIL auto_idle_ctrl: got %02h want 00", rd);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [7:0] rd;
    int b, base;
    bus_write(3'd2, 8'hA5);
    bus_write(3'd5, 8'd8);
    px_ready_i = 1'b0;
    got_q.delete();
    bus_write(3'd0, 8'h03);
    b = 0;
    while (!px_valid_o && b < 20) begin tick(); b++; end
    base = irq_cnt;
    #2 rst_n_i = 1'b0;
    #1;
    n_checks++;
    if (px_valid_o !== 1'b0 || px_data_o !== 24'h0 || frame_irq_o !== 1'b0)
      $display("FAIL async_reset_out: got %0b/%06h/%0b want 0/000000/0", px_valid_o, px_data_o, frame_irq_o);
    else n_pass++;
    m_reset();
    repeat (3) tick();
    rst_n_i = 1'b1;
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), rd);
      n_checks++;
      if (rd !== ((a == 5) ? m_count : ((a == 1) ? 8'(m_idx) : 8'h00)))
        $display("FAIL async_reg[%0d]: got %02h want %02h", a, rd, (a == 5) ? m_count : 8'h00);
      else n_pass++;
    end
    repeat (20) tick();
    n_checks++;
    if (irq_cnt !== base || px_valid_o !== 1'b0)
      $display("FAIL async_quiet: got %0d irq/%0b valid want 0/0", irq_cnt - base, px_valid_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_fill_wrap();
    test_ready_stall();
    test_pending();
    test_auto();
    test_async_reset();
    n_checks++;
    if (irq_long !== 0) $display("FAIL irq_width: got %0d long pulses want 0", irq_long);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
